// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single in-order memory port.
// An ID FIFO records which requester issued each accepted request so responses route back.
module mem_port_arbiter #(
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,

  input  logic               m0_req_i,
  output logic               m0_gnt_o,
  input  logic [31:0]        m0_addr_i,
  input  logic               m0_we_i,
  input  logic [MEM_W/8-1:0] m0_be_i,
  input  logic [MEM_W-1:0]   m0_wdata_i,
  output logic               m0_rvalid_o,
  output logic               m0_err_o,
  output logic [MEM_W-1:0]   m0_rdata_o,

  input  logic               m1_req_i,
  output logic               m1_gnt_o,
  input  logic [31:0]        m1_addr_i,
  input  logic               m1_we_i,
  input  logic [MEM_W/8-1:0] m1_be_i,
  input  logic [MEM_W-1:0]   m1_wdata_i,
  output logic               m1_rvalid_o,
  output logic               m1_err_o,
  output logic [MEM_W-1:0]   m1_rdata_o,

  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic               mem_err_i,
  input  logic [MEM_W-1:0]   mem_rdata_i,

  output logic               spurious_o
);

  localparam int unsigned BE_W  = MEM_W / 8;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Per-requester views so routing can be written once per index.
  logic [1:0]       req;
  logic [31:0]      addr  [2];
  logic             we    [2];
  logic [BE_W-1:0]  be    [2];
  logic [MEM_W-1:0] wdata [2];
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [1:0]       err;
  logic [MEM_W-1:0] rdata [2];

  assign req      = {m1_req_i, m0_req_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign we[0]    = m0_we_i;
  assign we[1]    = m1_we_i;
  assign be[0]    = m0_be_i;
  assign be[1]    = m1_be_i;
  assign wdata[0] = m0_wdata_i;
  assign wdata[1] = m1_wdata_i;

  logic             prio_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic             spurious_reg;
  logic             id_mem [MAX_OUTSTANDING];

  logic winner;
  logic space;
  logic accept;
  logic has_out;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A lone requester wins outright; contention falls back to the rotating priority.
  always_comb begin
    winner = prio_reg;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  // Space comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign space   = (cnt_reg < CNT_W'(MAX_OUTSTANDING));
  assign accept  = |gnt;
  assign has_out = (cnt_reg != '0);
  assign pop     = mem_rvalid_i && has_out;
  assign head    = id_mem[rd_ptr_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt[gi]    = rst_ni && space && req[gi] && (winner == 1'(gi));
    assign rvalid[gi] = rst_ni && pop && (head == 1'(gi));
    assign err[gi]    = rvalid[gi] ? mem_err_i : 1'b0;
    assign rdata[gi]  = rvalid[gi] ? mem_rdata_i : '0;
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_err_o    = err[0];
  assign m1_err_o    = err[1];
  assign m0_rdata_o  = rdata[0];
  assign m1_rdata_o  = rdata[1];

  assign mem_req_o   = accept;
  assign mem_addr_o  = accept ? addr[winner]  : '0;
  assign mem_we_o    = accept ? we[winner]    : 1'b0;
  assign mem_be_o    = accept ? be[winner]    : '0;
  assign mem_wdata_o = accept ? wdata[winner] : '0;
  assign spurious_o  = spurious_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_reg     <= 1'b0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      spurious_reg <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        prio_reg   <= ~winner;
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (mem_rvalid_i && !has_out) spurious_reg <= 1'b1;
      case ({accept, pop})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while cnt_reg says they are live.
  always_ff @(posedge clk_i) begin
    if (accept) id_mem[wr_ptr_reg] <= winner;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses into a
// scoreboard, a monitor pops them whenever either requester sees rvalid.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i = 0, m1_req_i = 0;
  logic [31:0] m0_addr_i = 0, m1_addr_i = 0;
  logic        m0_we_i = 0, m1_we_i = 0;
  logic [3:0]  m0_be_i = 0, m1_be_i = 0;
  logic [31:0] m0_wdata_i = 0, m1_wdata_i = 0;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i = 0, mem_err_i = 0;
  logic [31:0] mem_rdata_i = 0;
  logic        spurious_o;

  mem_port_arbiter #(.MEM_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  exp_t sb[$];
  rsp_t mq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic stall = 0;
  logic inj = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Read data the memory model returns for an address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Downstream memory: in order, one cycle minimum latency, optional stall and injection.
  initial begin
    logic cur_inj;
    rsp_t r;
    cur_inj = 0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        mq.delete();
      end else begin
        if (mem_rvalid_i && !cur_inj && mq.size() > 0) void'(mq.pop_front());
        if (mem_req_o) begin
          r.data = mem_we_o ? 32'h0 : rd_val(mem_addr_o);
          r.err  = mem_addr_o[31];
          mq.push_back(r);
        end
      end
      #1;
      cur_inj = 0;
      if (rst_ni && inj) begin
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0000; mem_err_i = 0; cur_inj = 1;
      end else if (rst_ni && !stall && mq.size() > 0) begin
        mem_rvalid_i = 1; mem_rdata_i = mq[0].data; mem_err_i = mq[0].err;
      end else begin
        mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (m0_rvalid_o || m1_rvalid_o) begin
        chk("resp_one_hot", {31'b0, m0_rvalid_o && m1_rvalid_o}, 32'h0);
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", {31'b0, m1_rvalid_o}, {31'b0, e.id});
          chk("resp_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, e.data);
          chk("resp_err", {31'b0, m1_rvalid_o ? m1_err_o : m0_err_o}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  initial begin
    logic [31:0] a0, a1;
    logic        expw, expg;

    // Reset: outputs forced low even with a request pending.
    m0_req_i = 1; m0_addr_i = 32'h55;
    tick(); tick();
    @(negedge clk_i);
    chk("rst_m0_gnt", {31'b0, m0_gnt_o}, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_spurious", {31'b0, spurious_o}, 32'h0);
    tick();
    m0_req_i = 0; rst_ni = 1;
    tick();

    // Single m0 read with one-cycle downstream latency.
    m0_req_i = 1; m0_addr_i = 32'h0000_2000; m0_we_i = 0;
    @(negedge clk_i);
    chk("t1_m0_gnt", {31'b0, m0_gnt_o}, 32'h1);
    chk("t1_m1_gnt", {31'b0, m1_gnt_o}, 32'h0);
    chk("t1_mem_req", {31'b0, mem_req_o}, 32'h1);
    chk("t1_mem_addr", mem_addr_o, 32'h0000_2000);
    expect_rsp(0, 32'hDEAD_BEEF, 0);
    tick();
    m0_req_i = 0;
    @(negedge clk_i);
    chk("t1_m0_rvalid", {31'b0, m0_rvalid_o}, 32'h1);
    chk("t1_m1_rvalid", {31'b0, m1_rvalid_o}, 32'h0);
    tick();

    // Fresh reset so priority restarts at m0, then continuous contention.
    rst_ni = 0; sb.delete();
    tick();
    rst_ni = 1;
    a0 = 32'h100; a1 = 32'h200;
    m0_req_i = 1; m1_req_i = 1; m0_addr_i = a0; m1_addr_i = a1;
    for (int i = 0; i < 6; i++) begin
      expw = 1'(i % 2);
      @(negedge clk_i);
      chk($sformatf("rr%0d_m0_gnt", i), {31'b0, m0_gnt_o}, {31'b0, ~expw});
      chk($sformatf("rr%0d_m1_gnt", i), {31'b0, m1_gnt_o}, {31'b0, expw});
      chk($sformatf("rr%0d_addr", i), mem_addr_o, expw ? a1 : a0);
      expect_rsp(expw, rd_val(expw ? a1 : a0), 0);
      tick();
      if (expw) begin a1 = a1 + 4; m1_addr_i = a1; end
      else begin a0 = a0 + 4; m0_addr_i = a0; end
    end
    m0_req_i = 0; m1_req_i = 0;
    tick(); tick(); tick();

    // Outstanding limit: four accepts, stall, first pop in cycle 6, grant returns in cycle 7.
    a0 = 32'h400; m0_addr_i = a0; m0_req_i = 1; stall = 1;
    for (int c = 0; c < 8; c++) begin
      expg = (c < 4) || (c == 7);
      @(negedge clk_i);
      chk($sformatf("lim%0d_gnt", c), {31'b0, m0_gnt_o}, {31'b0, expg});
      if (c == 5) chk("lim5_rvalid", {31'b0, m0_rvalid_o}, 32'h0);
      if (c == 6) chk("lim6_rvalid", {31'b0, m0_rvalid_o}, 32'h1);
      if (expg) expect_rsp(0, rd_val(a0), 0);
      tick();
      if (expg) begin a0 = a0 + 4; m0_addr_i = a0; end
      if (c == 4) stall = 0;
    end
    m0_req_i = 0;
    repeat (6) tick();

    // m1 write pass-through and response routing.
    m1_req_i = 1; m1_addr_i = 32'h3000; m1_we_i = 1; m1_be_i = 4'b0011; m1_wdata_i = 32'h1234_5678;
    @(negedge clk_i);
    chk("wr_m1_gnt", {31'b0, m1_gnt_o}, 32'h1);
    chk("wr_mem_we", {31'b0, mem_we_o}, 32'h1);
    chk("wr_mem_be", {28'b0, mem_be_o}, 32'h3);
    chk("wr_mem_wdata", mem_wdata_o, 32'h1234_5678);
    expect_rsp(1, 32'h0, 0);
    tick();
    m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
    @(negedge clk_i);
    chk("wr_m1_rvalid", {31'b0, m1_rvalid_o}, 32'h1);
    chk("wr_m0_rvalid", {31'b0, m0_rvalid_o}, 32'h0);
    chk("idle_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("idle_mem_wdata", mem_wdata_o, 32'h0);
    tick();

    // Error pass-through on a read.
    m0_req_i = 1; m0_addr_i = 32'h8000_0040;
    @(negedge clk_i);
    chk("err_m0_gnt", {31'b0, m0_gnt_o}, 32'h1);
    expect_rsp(0, 32'h0040_FFBF, 1);
    tick();
    m0_req_i = 0;
    tick(); tick();

    // Spurious response with nothing outstanding.
    @(negedge clk_i);
    chk("sp_before", {31'b0, spurious_o}, 32'h0);
    tick();
    inj = 1;
    tick();
    inj = 0;
    @(negedge clk_i);
    chk("sp_m0_rvalid", {31'b0, m0_rvalid_o}, 32'h0);
    chk("sp_m1_rvalid", {31'b0, m1_rvalid_o}, 32'h0);
    tick();
    @(negedge clk_i);
    chk("sp_set", {31'b0, spurious_o}, 32'h1);
    repeat (3) tick();
    @(negedge clk_i);
    chk("sp_sticky", {31'b0, spurious_o}, 32'h1);
    tick();
    rst_ni = 0;
    #1;
    chk("sp_cleared", {31'b0, spurious_o}, 32'h0);
    tick();
    rst_ni = 1;
    tick();

    // Reset with three outstanding requests.
    stall = 1; m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h600; m1_addr_i = 32'h700;
    repeat (3) tick();
    @(negedge clk_i);
    chk("r3_mem_req", {31'b0, mem_req_o}, 32'h1);
    tick();
    rst_ni = 0;
    #1;
    chk("r3_async_m0_gnt", {31'b0, m0_gnt_o}, 32'h0);
    chk("r3_async_m1_gnt", {31'b0, m1_gnt_o}, 32'h0);
    chk("r3_async_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("r3_async_mem_addr", mem_addr_o, 32'h0);
    sb.delete();
    tick();
    rst_ni = 1; stall = 0;
    @(negedge clk_i);
    chk("r3_first_m0_gnt", {31'b0, m0_gnt_o}, 32'h1);
    chk("r3_first_m1_gnt", {31'b0, m1_gnt_o}, 32'h0);
    chk("r3_first_addr", mem_addr_o, 32'h600);
    expect_rsp(0, rd_val(32'h600), 0);
    tick();
    m0_req_i = 0; m1_req_i = 0;
    repeat (4) tick();
    @(negedge clk_i);
    chk("end_spurious", {31'b0, spurious_o}, 32'h0);
    chk("end_sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
